fifo_port_arbiter: RTL and testbench

FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

---
 rtl/fifo_port_arbiter_pkg.sv | 19 +
 rtl/fifo_port_arbiter_fifo_15x8.sv | 36 +++
 rtl/fifo_port_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_port_arbiter_pkg.sv
// Shared constants, arbiter state type and pointer helper for the two-writer FIFO.
package fifo_port_arbiter_pkg;

   localparam int DEPTH_DEF = 15;
   localparam int WIDTH_DEF = 8;
   localparam int PTR_W     = 4;

   // Names the writer that wins when both request in the same cycle.
   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } arb_state_t;

   // Circular pointer increment: DEPTH-1 wraps back to 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
      return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_port_arbiter_fifo_15x8.sv
// Storage for the FIFO: register array with one write port and a registered read port.
module fifo_15x8
   import fifo_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array contents are data only; they are never cleared, pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register holds its value between pops so the last popped word stays visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Two-writer, one-reader FIFO with alternating-priority write arbitration,
// registered pop port, occupancy flags and a sticky underflow error.
module fifo_port_arbiter
   import fifo_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             gnt_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_b,
   input  logic             rd_req,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic [3:0]       count,
   output logic [9:0]       position,
   output logic             udf_err,
   input  logic             err_clr
);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] wr_data;

   // Flags come straight from registered count and pointers.
   assign full     = (count == 4'(DEPTH));
   assign empty    = (count == 4'd0);
   assign position = {wr_ptr, rd_ptr, full, empty};

   assign push    = gnt_a | gnt_b;
   assign pop     = rd_req & ~empty;
   assign wr_data = gnt_b ? data_b : data_a;

   // Grant decode: lone requester always wins, a tie goes to the writer named by state;
   // nothing is granted while full (even alongside a pop) or while in reset.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset && !full) begin
         if (req_a && (!req_b || state == PRI_A)) begin
            gnt_a = 1'b1;
         end else if (req_b) begin
            gnt_b = 1'b1;
         end
      end
   end

   // Next priority: hand the tie-break to the writer that was not just served.
   always_comb begin
      state_next = state;
      if (gnt_a) begin
         state_next = PRI_B;
      end else if (gnt_b) begin
         state_next = PRI_A;
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= PRI_A;
      end else begin
         state <= state_next;
      end
   end

   // Pointers, occupancy and read-valid pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr, DEPTH);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr, DEPTH);
         end
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // Sticky underflow flag; a clear wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (reset) begin
         udf_err <= 1'b0;
      end else if (err_clr) begin
         udf_err <= 1'b0;
      end else if (rd_req && empty) begin
         udf_err <= 1'b1;
      end
   end

   fifo_15x8 #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: arbitration order, fill to full,
// pop-while-full, pointer wrap, underflow error handling and mid-run reset.
module tb_fifo_port_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a, req_b, rd_req, err_clr;
   logic [7:0] data_a, data_b;
   logic       gnt_a, gnt_b, rd_valid, full, empty, udf_err;
   logic [7:0] rd_data;
   logic [3:0] count;
   logic [9:0] position;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req_a    (req_a),
      .data_a   (data_a),
      .gnt_a    (gnt_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .gnt_b    (gnt_b),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .position (position),
      .udf_err  (udf_err),
      .err_clr  (err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] p;
      reset = 1'b1; req_a = 1'b1; req_b = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
      data_a = 8'h00; data_b = 8'h00;
      #1;
      chk("gnt_a_in_reset", gnt_a, 0);
      tick();
      tick();
      req_a = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_position", position, 10'b0000000001);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_udf_err", udf_err, 0);
      chk("rst_rd_data", rd_data, 8'h00);

      // Simultaneous push: A first (PRI_A), then B.
      req_a = 1'b1; data_a = 8'h11; req_b = 1'b1; data_b = 8'h22;
      #1;
      chk("tie1_gnt_a", gnt_a, 1);
      chk("tie1_gnt_b", gnt_b, 0);
      tick();
      req_a = 1'b0;
      #1;
      chk("tie2_gnt_b", gnt_b, 1);
      chk("tie2_gnt_a", gnt_a, 0);
      tick();
      req_b = 1'b0;
      chk("two_count", count, 2);
      chk("two_position", position, 10'h080);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("pop1_valid", rd_valid, 1);
      chk("pop1_data", rd_data, 8'h11);
      tick();
      chk("pop1_valid_pulse", rd_valid, 0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("pop2_valid", rd_valid, 1);
      chk("pop2_data", rd_data, 8'h22);
      chk("pop2_empty", empty, 1);
      chk("pop2_position", position, 10'h089);

      // Both writers held high: alternate A,B,... for exactly 15 grants.
      req_a = 1'b1; req_b = 1'b1;
      for (int i = 0; i < 15; i++) begin
         data_a = 8'(i); data_b = 8'(i);
         #1;
         chk("fill_gnt_a", gnt_a, (i % 2 == 0) ? 1 : 0);
         chk("fill_gnt_b", gnt_b, (i % 2 == 1) ? 1 : 0);
         tick();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 15);
      chk("full_no_gnt_a", gnt_a, 0);
      chk("full_no_gnt_b", gnt_b, 0);
      tick();
      chk("full_count_hold", count, 15);
      chk("full_position", position, 10'h08A);

      // Pop while full with A requesting: no grant that cycle, A granted next.
      req_b = 1'b0; data_a = 8'h55; rd_req = 1'b1;
      #1;
      chk("popfull_no_gnt", gnt_a, 0);
      tick();
      rd_req = 1'b0;
      #1;
      chk("popfull_valid", rd_valid, 1);
      chk("popfull_data", rd_data, 8'h00);
      chk("popfull_count", count, 14);
      chk("popfull_gnt_next", gnt_a, 1);
      tick();
      req_a = 1'b0;
      chk("refill_count", count, 15);
      chk("refill_full", full, 1);

      // Fresh start, then 20 push/pop pairs to wrap both pointers.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         req_a = 1'b1; data_a = 8'(i);
         #1;
         chk("wrap_gnt_a", gnt_a, 1);
         tick();
         req_a = 1'b0; rd_req = 1'b1;
         tick();
         rd_req = 1'b0;
         p = 4'((i + 1) % 15);
         chk("wrap_valid", rd_valid, 1);
         chk("wrap_data", rd_data, 8'(i));
         chk("wrap_position", position, {p, p, 2'b01});
      end

      // Underflow: sticky flag, clear, and clear winning over a same-cycle set.
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("udf_valid", rd_valid, 0);
      chk("udf_set", udf_err, 1);
      chk("udf_rd_data_hold", rd_data, 8'h13);
      chk("udf_position", position, 10'h155);
      tick();
      chk("udf_sticky", udf_err, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("udf_clear", udf_err, 0);
      err_clr = 1'b1; rd_req = 1'b1;
      tick();
      err_clr = 1'b0; rd_req = 1'b0;
      chk("udf_clr_priority", udf_err, 0);
      chk("udf_clr_valid", rd_valid, 0);

      // Seven entries (last from A leaves PRI_B), then reset mid-operation.
      req_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_b = 8'(8'hB0 + i);
         tick();
      end
      req_b = 1'b0; req_a = 1'b1; data_a = 8'hA6;
      tick();
      chk("pre_rst_count", count, 7);
      reset = 1'b1;
      #1;
      chk("rst_mid_no_gnt", gnt_a, 0);
      tick();
      reset = 1'b0; req_a = 1'b0;
      chk("rst_mid_count", count, 0);
      chk("rst_mid_empty", empty, 1);
      chk("rst_mid_position", position, 10'b0000000001);
      chk("rst_mid_rd_data", rd_data, 8'h00);
      req_a = 1'b1; req_b = 1'b1;
      #1;
      chk("rst_mid_state_a", gnt_a, 1);
      chk("rst_mid_state_b", gnt_b, 0);
      req_a = 1'b0; req_b = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
